// File: rtl/cmult_sched_pkg.sv
// cmult_sched_pkg: shared constants, types and helpers for the cmult_sched
// slice.
//   LAT        multiplier latency in clock edges (capture edge counted as 1)
//   SB_IDW     id field width of the side-band word (covers NREQ up to 8)
//   SB_TAGW    tag field width of the side-band word (covers TAGW up to 8)
//   id_width() width needed to encode an index below n (at least 1)
//   sideband_t {valid, id, tag} word that travels alongside the multiplier
package cmult_sched_pkg;

  localparam int unsigned LAT     = 6;
  localparam int unsigned SB_IDW  = 3;
  localparam int unsigned SB_TAGW = 8;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [SB_IDW-1:0]  id;
    logic [SB_TAGW-1:0] tag;
  } sideband_t;

endpackage

// File: rtl/cmult_sched_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal rotating pointer.
//   clk, rst_n  clock, synchronous active-low reset (pointer -> 0)
//   i_req       request vector (already masked by credit availability)
//   i_accept    a grant was taken this cycle; pointer moves past the winner
//   o_grant     one-hot grant, first request at or above the pointer (wrap)
//   o_grant_id  binary index of the granted requester
module rr_arbiter
  import cmult_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             i_req,
  input  logic                        i_accept,
  output logic [NREQ-1:0]             o_grant,
  output logic [id_width(NREQ)-1:0]   o_grant_id
);

  localparam int unsigned IDW = id_width(NREQ);

  logic [IDW-1:0] r_ptr;
  logic           w_found;

  // Requester i sits at distance off from the pointer when
  // (i - off) mod NREQ == r_ptr; scanning off upward gives RR priority
  // using only constant indices.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!w_found && i_req[i] &&
            (IDW'((i + NREQ - off) % NREQ) == r_ptr)) begin
          w_found    = 1'b1;
          o_grant[i] = 1'b1;
          o_grant_id = IDW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= (o_grant_id == IDW'(NREQ - 1)) ? '0 : o_grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/cmult_sched.sv
// cmult_sched: round-robin scheduler sharing one 3-multiplier complex
// multiplier among NREQ requesters, with results returned in issue order
// through a credit-protected FIFO.
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_ar/ai         packed signed a operands, AWIDTH each
//   req_br/bi         packed signed b operands, BWIDTH each
//   req_tag           packed user tags, TAGW each
//   out_valid/ready   result handshake, head of the result FIFO
//   out_pr/pi         full-precision product, AWIDTH+BWIDTH+1 bits signed
//   out_id/out_tag    originating requester and its tag
module cmult_sched
  import cmult_sched_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned AWIDTH     = 16,
  parameter int unsigned BWIDTH     = 18,
  parameter int unsigned TAGW       = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*AWIDTH-1:0]      req_ar,
  input  logic [NREQ*AWIDTH-1:0]      req_ai,
  input  logic [NREQ*BWIDTH-1:0]      req_br,
  input  logic [NREQ*BWIDTH-1:0]      req_bi,
  input  logic [NREQ*TAGW-1:0]        req_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [AWIDTH+BWIDTH:0]      out_pr,
  output logic [AWIDTH+BWIDTH:0]      out_pi,
  output logic [id_width(NREQ)-1:0]   out_id,
  output logic [TAGW-1:0]             out_tag
);

  localparam int unsigned PW   = AWIDTH + BWIDTH + 1;
  localparam int unsigned IDW  = id_width(NREQ);
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTRW = id_width(FIFO_DEPTH);

  if (NREQ < 2 || NREQ > (1 << SB_IDW)) begin : g_bad_nreq
    $error("cmult_sched: NREQ must be within 2..8");
  end
  if (TAGW > SB_TAGW) begin : g_bad_tagw
    $error("cmult_sched: TAGW exceeds side-band tag width");
  end
  if (FIFO_DEPTH < LAT + 2) begin : g_bad_depth
    $error("cmult_sched: FIFO_DEPTH must be at least LAT+2");
  end

  // ---------------------------------------------------------------- arbiter
  logic            w_credit;
  logic [NREQ-1:0] w_arb_req;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gid;
  logic            w_accept;
  logic [CNTW-1:0] r_cnt;

  // Pops do not add credit in the same cycle; ready stays low in reset.
  assign w_credit  = rst_n && (r_cnt < CNTW'(FIFO_DEPTH));
  assign w_arb_req = w_credit ? req_valid : '0;
  assign req_ready = w_grant;
  assign w_accept  = |w_grant;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (w_arb_req),
    .i_accept   (w_accept),
    .o_grant    (w_grant),
    .o_grant_id (w_gid)
  );

  // ------------------------------------------------------------ operand mux
  logic signed [AWIDTH-1:0] w_ar, w_ai;
  logic signed [BWIDTH-1:0] w_br, w_bi;
  logic [TAGW-1:0]          w_tag;

  always_comb begin
    w_ar  = '0;
    w_ai  = '0;
    w_br  = '0;
    w_bi  = '0;
    w_tag = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_ar  = req_ar[i*AWIDTH +: AWIDTH];
        w_ai  = req_ai[i*AWIDTH +: AWIDTH];
        w_br  = req_br[i*BWIDTH +: BWIDTH];
        w_bi  = req_bi[i*BWIDTH +: BWIDTH];
        w_tag = req_tag[i*TAGW +: TAGW];
      end
    end
  end

  // ------------------------------------------------------------- multiplier
  // Three-multiplier form, LAT = 6 register stages, no reset:
  //   common = (ar - ai) * bi
  //   pr     = ar * (br - bi) + common
  //   pi     = ai * (br + bi) + common
  // Every partial product fits in PW bits and so does each final result,
  // so all arithmetic is done modulo 2^PW without loss.
  logic signed [AWIDTH-1:0] r_ar1, r_ai1, r_ar2, r_ai2;
  logic signed [BWIDTH-1:0] r_br1, r_bi1, r_bi2;
  logic signed [AWIDTH:0]   r_dab2;
  logic signed [BWIDTH:0]   r_dbb2, r_sbb2;
  logic signed [PW-1:0]     r_mc3, r_mr3, r_mi3;
  logic signed [PW-1:0]     r_mc4, r_mr4, r_mi4;
  logic signed [PW-1:0]     r_pr5, r_pi5, r_pr6, r_pi6;

  always_ff @(posedge clk) begin
    // Stage 1 holds its operands while idle so the datapath stays quiet.
    if (w_accept) begin
      r_ar1 <= w_ar;
      r_ai1 <= w_ai;
      r_br1 <= w_br;
      r_bi1 <= w_bi;
    end
    r_ar2  <= r_ar1;
    r_ai2  <= r_ai1;
    r_bi2  <= r_bi1;
    r_dab2 <= (AWIDTH+1)'(r_ar1) - (AWIDTH+1)'(r_ai1);
    r_dbb2 <= (BWIDTH+1)'(r_br1) - (BWIDTH+1)'(r_bi1);
    r_sbb2 <= (BWIDTH+1)'(r_br1) + (BWIDTH+1)'(r_bi1);
    r_mc3  <= PW'(r_dab2) * PW'(r_bi2);
    r_mr3  <= PW'(r_ar2) * PW'(r_dbb2);
    r_mi3  <= PW'(r_ai2) * PW'(r_sbb2);
    r_mc4  <= r_mc3;
    r_mr4  <= r_mr3;
    r_mi4  <= r_mi3;
    r_pr5  <= r_mr4 + r_mc4;
    r_pi5  <= r_mi4 + r_mc4;
    r_pr6  <= r_pr5;
    r_pi6  <= r_pi5;
  end

  // -------------------------------------------------------------- side-band
  sideband_t r_sb [LAT];
  sideband_t w_sb_in;
  sideband_t w_sb_tail;

  always_comb begin
    w_sb_in       = '0;
    w_sb_in.valid = w_accept;
    w_sb_in.id    = SB_IDW'(w_gid);
    w_sb_in.tag   = SB_TAGW'(w_tag);
  end

  assign w_sb_tail = r_sb[LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        r_sb[k] <= '0;
      end
    end else begin
      r_sb[0] <= w_sb_in;
      for (int unsigned k = 1; k < LAT; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  // ------------------------------------------------------------ result FIFO
  logic [PW-1:0]   r_mem_pr  [FIFO_DEPTH];
  logic [PW-1:0]   r_mem_pi  [FIFO_DEPTH];
  logic [IDW-1:0]  r_mem_id  [FIFO_DEPTH];
  logic [TAGW-1:0] r_mem_tag [FIFO_DEPTH];
  logic [PTRW-1:0] r_wr, r_rd;
  logic [CNTW-1:0] r_occ;
  logic            w_push, w_pop;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push    = w_sb_tail.valid;
  assign out_valid = (r_occ != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_pr    = r_mem_pr[r_rd];
  assign out_pi    = r_mem_pi[r_rd];
  assign out_id    = r_mem_id[r_rd];
  assign out_tag   = r_mem_tag[r_rd];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_occ <= '0;
      r_cnt <= '0;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        r_mem_pr[k]  <= '0;
        r_mem_pi[k]  <= '0;
        r_mem_id[k]  <= '0;
        r_mem_tag[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_pr[r_wr]  <= r_pr6;
        r_mem_pi[r_wr]  <= r_pi6;
        r_mem_id[r_wr]  <= w_sb_tail.id[IDW-1:0];
        r_mem_tag[r_wr] <= w_sb_tail.tag[TAGW-1:0];
        r_wr            <= ptr_inc(r_wr);
      end
      if (w_pop) begin
        r_rd <= ptr_inc(r_rd);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      // Credit counts a result from accept until it leaves the FIFO.
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ------------------------------------------------------------- assertions
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_occ == CNTW'(FIFO_DEPTH))));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_cnt <= CNTW'(FIFO_DEPTH));

  a_sideband_range: assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> (((w_sb_tail.id >> IDW) == '0) && ((w_sb_tail.tag >> TAGW) == '0)));

endmodule

// File: tb/tb_cmult_sched.sv
module tb_cmult_sched;

  localparam int NREQ = 4;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*16-1:0] req_ar, req_ai;
  logic [NREQ*18-1:0] req_br, req_bi;
  logic [NREQ*4-1:0]  req_tag;
  logic             out_valid;
  logic             out_ready;
  logic [34:0]      out_pr, out_pi;
  logic [1:0]       out_id;
  logic [3:0]       out_tag;

  cmult_sched #(
    .NREQ       (4),
    .AWIDTH     (16),
    .BWIDTH     (18),
    .TAGW       (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ar    (req_ar),
    .req_ai    (req_ai),
    .req_br    (req_br),
    .req_bi    (req_bi),
    .req_tag   (req_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pr    (out_pr),
    .out_pi    (out_pi),
    .out_id    (out_id),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int                 id;
    logic [3:0]         tag;
    logic signed [63:0] pr;
    logic signed [63:0] pi;
  } exp_t;

  exp_t q[$];

  logic [3:0]         tb_tag [NREQ];
  logic signed [63:0] tb_epr [NREQ];
  logic signed [63:0] tb_epi [NREQ];

  // Operands for requester i plus the hand-computed product they must yield.
  task automatic set_req(input int i, input int ar, input int ai, input int br,
                         input int bi, input int tag, input longint epr,
                         input longint epi);
    req_ar[i*16 +: 16] = 16'(ar);
    req_ai[i*16 +: 16] = 16'(ai);
    req_br[i*18 +: 18] = 18'(br);
    req_bi[i*18 +: 18] = 18'(bi);
    req_tag[i*4 +: 4]  = 4'(tag);
    tb_tag[i] = 4'(tag);
    tb_epr[i] = epr;
    tb_epi[i] = epi;
  endtask

  task automatic load_table();
    set_req(0,      3,    4,   5,  6,  5,       -9,     38);
    set_req(1,     -7,    2,  10, -3,  9,      -64,     41);
    set_req(2,   1000,   -1,  -2, 500, 10,    -1500, 500002);
    set_req(3, -12345, 6789, 100, -1, 15, -1227711, 691245);
  endtask

  // Called one time unit after an edge with inputs set: checks the grant,
  // records the expected result, then advances to just after the next edge.
  task automatic step(input logic [3:0] exp_rdy);
    #1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < NREQ; i++) begin
      if (exp_rdy[i]) q.push_back('{i, tb_tag[i], tb_epr[i], tb_epi[i]});
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    repeat (2) begin
      #1;
      check("rst_ready", 64'(req_ready), 0);
      @(posedge clk); #1;
    end
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_pr", 64'($signed(out_pr)), 0);
    check("rst_out_pi", 64'($signed(out_pi)), 0);
    check("rst_out_id", 64'(out_id), 0);
    check("rst_out_tag", 64'(out_tag), 0);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", 64'(q.size()), 0);
    @(posedge clk); #1;
    check("idle_out_valid", 64'(out_valid), 0);
  endtask

  // Every pop is compared against the next expected result in issue order.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("out_unexpected", 64'(out_valid), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_id", 64'(out_id), 64'(e.id));
        check("out_tag", 64'(out_tag), 64'(e.tag));
        check("out_pr", 64'($signed(out_pr)), e.pr);
        check("out_pi", 64'($signed(out_pi)), e.pi);
      end
    end
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    req_ar = '0; req_ai = '0; req_br = '0; req_bi = '0; req_tag = '0;
    load_table();
    @(posedge clk); #1;
    do_reset();
    req_valid = '0;

    // Single request from 0: latency and one-cycle result.
    req_valid = 4'b0001;
    step(4'b0001);
    req_valid = '0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 6);
    @(posedge clk); #1;
    check("single_one_cycle", 64'(out_valid), 0);
    drain(20);

    // All four streaming with out_ready high.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 16; k++) step(4'(1 << (k % 4)));
    req_valid = '0;
    drain(20);

    // Back-pressure: eight accepts then stall, drain, resume.
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) step(4'(1 << (k % 4)));
    for (int k = 0; k < 10; k++) step(4'b0000);
    out_ready = 1'b1;
    step(4'b0000);
    step(4'b0001);
    req_valid = '0;
    drain(30);

    // Extreme operands.
    set_req(0, -32768, -32768, -131072, -131072, 3, 0, 64'sd8589934592);
    req_valid = 4'b0001;
    step(4'b0001);
    set_req(2, -32768, 32767, -131072, 131071, 12, 163839, -64'sd8589770752);
    req_valid = 4'b0100;
    step(4'b0100);
    req_valid = '0;
    drain(20);

    // Reset while two products are in flight.
    load_table();
    do_reset();
    req_valid = 4'b0011;
    step(4'b0001);
    step(4'b0010);
    req_valid = '0;
    repeat (3) step(4'b0000);
    req_valid = 4'b0100;
    do_reset();
    req_valid = 4'b1111;
    #1;
    check("post_rst_ptr0", 64'(req_ready), 64'(4'b0001));
    req_valid = 4'b0100;
    step(4'b0100);
    req_valid = '0;
    drain(20);

    // Pointer at 2 with requesters 1 and 3 pending.
    do_reset();
    req_valid = 4'b0010;
    step(4'b0010);
    req_valid = 4'b1010;
    step(4'b1000);
    step(4'b0010);
    step(4'b1000);
    req_valid = 4'b0000;
    step(4'b0000);
    step(4'b0000);
    drain(20);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
